return_addr_stack: RTL
======================

Name: return_addr_stack

Overview:
- Hardware return-address stack (RAS) for the 19-bit single-cycle core.
- Pushes the return address on a call and supplies the popped address on a return.
- Sits beside the next-PC logic. It consumes the same call_en/ret_en strobes that select the next PC, and drives stk_ret_inst, which the next-PC mux selects on ret_en.
- Circular storage with occupancy tracking and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 19, address width in bits.
- DEPTH, 8, number of entries. Must be a power of 2, at least 2.
- PTR_W, 3, pointer width, log2(DEPTH).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- call_en  input  1  push request, sampled at the clk rising edge.
- ret_en  input  1  pop request, sampled at the clk rising edge.
- stall  input  1  when 1, call_en/ret_en are ignored for this cycle.
- ret_addr_in  input  WIDTH  address to push (PC+4 of the call instruction).
- clr_err  input  1  synchronous clear of the sticky error flags.
- stk_ret_inst  output  WIDTH  current top-of-stack entry; combinational from state.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set on a push while full.
- underflow  output  1  sticky; set on a pop while empty.

Behaviour:
- State:
  - sp (PTR_W bits) = index of the next free slot. top index = sp-1 mod DEPTH.
  - cnt (PTR_W+1 bits).
  - mem[DEPTH] of WIDTH bits.
- Reset (rst=0, asynchronous):
  - sp=0, cnt=0, overflow=0, underflow=0. All mem entries cleared to 0.
  - Therefore stk_ret_inst=0, count=0, empty=1, full=0 immediately, without waiting for a clock edge.
- Read path:
  - stk_ret_inst = mem[sp-1 mod DEPTH] when cnt!=0, else 0.
  - Zero latency: the same cycle a ret_en is presented, stk_ret_inst already holds the target for the next-PC mux.
- Effective operation per rising edge:
  - push = call_en & ~stall.
  - pop = ret_en & ~call_en & ~stall.
  - call_en and ret_en both 1 -> push only. This matches the next-PC priority, where call wins over ret.
- Push, not full: mem[sp]<=ret_addr_in; sp<=sp+1 (wraps DEPTH-1 -> 0); cnt<=cnt+1.
- Push, full:
  - mem[sp]<=ret_addr_in, overwriting the oldest entry; sp<=sp+1 with wrap; cnt stays DEPTH.
  - overflow<=1.
  - The newest DEPTH return addresses stay correct.
- Pop, not empty: sp<=sp-1 (wraps 0 -> DEPTH-1); cnt<=cnt-1. mem is unchanged.
- Pop, empty: sp, cnt and mem unchanged; underflow<=1. stk_ret_inst stays 0 for that cycle.
- No operation, or stall=1: all state holds.
- clr_err=1: overflow<=0 and underflow<=0 on that edge.
  - If the same edge also sets a flag (push-full or pop-empty), the set wins and the flag reads 1.
- empty and full are pure decodes of cnt; no registered lag.
- Reset asserted mid-sequence discards all contents. The first ret after reset produces underflow.

Test Plan:
- Reset then idle -> stk_ret_inst=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Push 0x00100, 0x00200, 0x00300 on consecutive cycles -> count=3; stk_ret_inst=0x00300.
  - Then three rets -> stk_ret_inst shows 0x00200, 0x00100, 0 after each edge; count ends at 0; underflow stays 0.
- Push 9 values 0x00010..0x00090 with DEPTH=8 -> full=1 after the 8th push and overflow=1 after the 9th; count=8.
  - Then 8 pops -> reads 0x00090 down to 0x00020; empty=1.
- ret_en while empty -> underflow=1, count stays 0.
  - clr_err pulse -> underflow=0.
  - clr_err and ret_en on the same edge while empty -> underflow=1.
- call_en=ret_en=1 with ret_addr_in=0x7FFFC and count=2 -> push only: count=3, stk_ret_inst=0x7FFFC.
  - stall=1 with call_en=1 -> count unchanged.
- Push 0x00AAA, 0x00BBB, then assert rst low between clock edges -> outputs read reset values immediately.
  - Next ret -> underflow=1.

Source files
------------

// File: rtl/return_addr_stack_if.sv
// Core-side bundle for the return-address stack: call/ret strobes, stall and
// error clear from the next-PC logic, plus the top-of-stack target and
// occupancy/error status going back to it.
interface return_addr_stack_if #(
    parameter int WIDTH = 19,
    parameter int PTR_W = 3
);
    // Strobe semantics: there is no ready/back-pressure. call_en and ret_en
    // are single-cycle requests sampled on every rising clk edge that stall
    // is low; call_en wins when both are high. The stack always accepts a
    // request: a push while full overwrites the oldest entry, and a pop while
    // empty is dropped. Both cases raise a sticky error flag instead of
    // refusing the request.
    logic             call_en;
    logic             ret_en;
    logic             stall;
    logic [WIDTH-1:0] ret_addr_in;
    logic             clr_err;
    logic [WIDTH-1:0] stk_ret_inst;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output call_en, ret_en, stall, ret_addr_in, clr_err,
        input  stk_ret_inst, count, empty, full, overflow, underflow
    );

    modport slave (
        input  call_en, ret_en, stall, ret_addr_in, clr_err,
        output stk_ret_inst, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A call pushes PC+4 and a return pops it.
// The top entry is presented combinationally, so the next-PC mux sees the
// return target in the same cycle that ret_en is raised. When the stack is
// full, a push overwrites the oldest entry. In that case the newest DEPTH
// addresses remain correct and a sticky overflow flag records the loss.
module return_addr_stack #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    return_addr_stack_if.slave   bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W:0]   cnt;
    logic             overflow_q;
    logic             underflow_q;

    logic             push;
    logic             pop;
    logic             is_empty;
    logic             is_full;
    logic [PTR_W-1:0] top_idx;

    // Decode the effective operation. Call takes priority over ret, which
    // matches the next-PC mux.
    always_comb begin
        push     = bus.call_en & ~bus.stall;
        pop      = bus.ret_en & ~bus.call_en & ~bus.stall;
        is_empty = (cnt == '0);
        is_full  = (cnt == (PTR_W+1)'(DEPTH));
        top_idx  = sp - PTR_W'(1);
    end

    // Pointer, occupancy, storage and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp          <= '0;
            cnt         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[sp] <= bus.ret_addr_in;
                sp      <= sp + PTR_W'(1);
                if (!is_full) begin
                    cnt <= cnt + (PTR_W+1)'(1);
                end
            end else if (pop && !is_empty) begin
                sp  <= sp - PTR_W'(1);
                cnt <= cnt - (PTR_W+1)'(1);
            end
            // A flag that is set on the same edge as clr_err takes priority over the clear.
            overflow_q  <= (push & is_full) | (overflow_q & ~bus.clr_err);
            underflow_q <= (pop & is_empty) | (underflow_q & ~bus.clr_err);
        end
    end

    // Drive the status outputs as pure decodes of the current state.
    always_comb begin
        bus.stk_ret_inst = is_empty ? '0 : mem[top_idx];
        bus.count        = cnt;
        bus.empty        = is_empty;
        bus.full         = is_full;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end
endmodule
